// File: rtl/rvfi_commit_monitor.sv
// End-of-test and retirement monitor for the multi-port RVFI commit bus.
// Detects tohost termination, global timeout and commit hang; counts retirements and traps.
module rvfi_commit_monitor #(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned CNT_WIDTH       = 48,
  parameter int unsigned TIMEOUT_CYCLES  = 2000000,
  parameter int unsigned HANG_CYCLES     = 100000
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  clear_i,
  input  logic [XLEN-1:0]                       tohost_addr_i,
  input  logic [NR_COMMIT_PORTS-1:0]            valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]            trap_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]       mem_addr_i,
  input  logic [NR_COMMIT_PORTS*(XLEN/8)-1:0]   mem_wmask_i,
  input  logic [NR_COMMIT_PORTS*XLEN-1:0]       mem_wdata_i,
  output logic                                  done_o,
  output logic [1:0]                            end_reason_o,
  output logic [63:0]                           exit_code_o,
  output logic [CNT_WIDTH-1:0]                  cycles_o,
  output logic [CNT_WIDTH-1:0]                  instret_o,
  output logic [CNT_WIDTH-1:0]                  trap_cnt_o,
  output logic                                  order_err_o
);

  localparam int unsigned MaskW = XLEN / 8;
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HangLast    = CNT_WIDTH'(HANG_CYCLES - 1);

  localparam logic [1:0] ReasonTohost  = 2'b01;
  localparam logic [1:0] ReasonTimeout = 2'b10;
  localparam logic [1:0] ReasonHang    = 2'b11;

  typedef enum logic [1:0] {StRun, StLoSeen, StDone} state_e;

  state_e                state_q, state_d, scan_state;
  logic [1:0]            reason_q, reason_d;
  logic [63:0]           exit_q, exit_d, scan_exit;
  logic [31:0]           lo_q, lo_d, scan_lo;
  logic [CNT_WIDTH-1:0]  cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0]  idle_q, idle_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic [CNT_WIDTH-1:0]  trap_cnt_q, trap_cnt_d;
  logic                  order_err_q, order_err_d;

  logic [XLEN-1:0]       tohost_hi;
  logic [XLEN-1:0]       p_addr, p_wdata;
  logic [MaskW-1:0]      p_mask;
  logic                  p_lo, p_hi;
  logic                  scan_stop, tohost_done;
  logic                  any_valid, gap, timeout_hit, hang_hit;
  logic [CNT_WIDTH:0]    ret_inc, trap_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH:0]   b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + b;
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign tohost_hi   = tohost_addr_i + XLEN'(4);
  assign any_valid   = |valid_i;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycles_q == TimeoutLast);
  assign hang_hit    = (HANG_CYCLES != 0) && !any_valid && (idle_q == HangLast);

  // Per-cycle commit statistics and out-of-order port usage.
  always_comb begin
    ret_inc  = '0;
    trap_inc = '0;
    gap      = 1'b0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      ret_inc  = ret_inc + {{CNT_WIDTH{1'b0}}, valid_i[i] & ~trap_i[i]};
      trap_inc = trap_inc + {{CNT_WIDTH{1'b0}}, trap_i[i]};
      for (int j = 0; j < i; j++) begin
        if (valid_i[i] && !valid_i[j]) gap = 1'b1;
      end
    end
  end

  // Walk ports in index order; in 32-bit mode a lo/hi pair may complete within one cycle.
  always_comb begin
    scan_state  = state_q;
    scan_lo     = lo_q;
    scan_exit   = exit_q;
    tohost_done = 1'b0;
    scan_stop   = 1'b0;
    p_addr      = '0;
    p_wdata     = '0;
    p_mask      = '0;
    p_lo        = 1'b0;
    p_hi        = 1'b0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      p_addr  = mem_addr_i[i*XLEN +: XLEN];
      p_wdata = mem_wdata_i[i*XLEN +: XLEN];
      p_mask  = mem_wmask_i[i*MaskW +: MaskW];
      p_lo    = valid_i[i] && (|p_mask) && (tohost_addr_i != '0) && (p_addr == tohost_addr_i);
      p_hi    = valid_i[i] && (|p_mask) && (tohost_addr_i != '0) && (p_addr == tohost_hi);
      if (!scan_stop && state_q != StDone) begin
        if (XLEN == 64) begin
          if (p_lo) begin
            scan_stop = 1'b1;
            if (p_wdata[0] && p_wdata[XLEN-1 -: 16] == '0) begin
              tohost_done = 1'b1;
              scan_exit   = 64'(p_wdata);
            end
          end
        end else begin
          if (p_lo) begin
            if (scan_state == StLoSeen || p_wdata[0]) begin
              scan_state = StLoSeen;
              scan_lo    = 32'(p_wdata);
            end
          end else if (p_hi && scan_state == StLoSeen) begin
            if (p_wdata[XLEN-1 -: 16] == '0) begin
              tohost_done = 1'b1;
              scan_stop   = 1'b1;
              scan_exit   = {32'(p_wdata), scan_lo};
            end else begin
              scan_state = StRun;
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    exit_d      = exit_q;
    lo_d        = lo_q;
    cycles_d    = cycles_q;
    idle_d      = idle_q;
    instret_d   = instret_q;
    trap_cnt_d  = trap_cnt_q;
    order_err_d = order_err_q | gap;
    if (state_q != StDone) begin
      cycles_d   = cycles_q + CNT_WIDTH'(1);
      idle_d     = any_valid ? '0 : idle_q + CNT_WIDTH'(1);
      instret_d  = sat_add(instret_q, ret_inc);
      trap_cnt_d = sat_add(trap_cnt_q, trap_inc);
      state_d    = scan_state;
      lo_d       = scan_lo;
      if (tohost_done) begin
        state_d  = StDone;
        reason_d = ReasonTohost;
        exit_d   = scan_exit;
      end else if (timeout_hit) begin
        state_d  = StDone;
        reason_d = ReasonTimeout;
      end else if (hang_hit) begin
        state_d  = StDone;
        reason_d = ReasonHang;
      end
    end
    if (clear_i) begin
      state_d     = StRun;
      reason_d    = '0;
      exit_d      = '0;
      lo_d        = '0;
      cycles_d    = '0;
      idle_d      = '0;
      instret_d   = '0;
      trap_cnt_d  = '0;
      order_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      reason_q    <= '0;
      exit_q      <= '0;
      lo_q        <= '0;
      cycles_q    <= '0;
      idle_q      <= '0;
      instret_q   <= '0;
      trap_cnt_q  <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      exit_q      <= exit_d;
      lo_q        <= lo_d;
      cycles_q    <= cycles_d;
      idle_q      <= idle_d;
      instret_q   <= instret_d;
      trap_cnt_q  <= trap_cnt_d;
      order_err_q <= order_err_d;
    end
  end

  assign done_o       = (state_q == StDone);
  assign end_reason_o = reason_q;
  assign exit_code_o  = exit_q;
  assign cycles_o     = cycles_q;
  assign instret_o    = instret_q;
  assign trap_cnt_o   = trap_cnt_q;
  assign order_err_o  = order_err_q;

endmodule

// File: tb/tb_rvfi_commit_monitor.sv
// Scoreboard bench: a 64-bit instance (timeout 100, hang 50) and a 32-bit instance (no limits).
module tb_rvfi_commit_monitor;

  typedef struct packed {
    logic [1:0]  reason;
    logic [63:0] exit_code;
    logic [47:0] cycles;
    logic [47:0] instret;
    logic [47:0] traps;
    logic        order_err;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_n;
  always #5 clk_i = ~clk_i;

  // 64-bit instance signals
  logic         clear_a;
  logic [63:0]  tohost_a;
  logic [1:0]   valid_a, trap_a;
  logic [127:0] addr_a, wdata_a;
  logic [15:0]  wmask_a;
  logic         done_a, order_a;
  logic [1:0]   reason_a;
  logic [63:0]  exit_a;
  logic [47:0]  cycles_a, instret_a, traps_a;

  // 32-bit instance signals
  logic         clear_b;
  logic [31:0]  tohost_b;
  logic [1:0]   valid_b, trap_b;
  logic [63:0]  addr_b, wdata_b;
  logic [7:0]   wmask_b;
  logic         done_b, order_b;
  logic [1:0]   reason_b;
  logic [63:0]  exit_b;
  logic [47:0]  cycles_b, instret_b, traps_b;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic prev_a, prev_b;

  localparam logic [63:0] TA  = 64'h8000_1000;
  localparam logic [31:0] TB  = 32'h8000_2000;
  localparam logic [31:0] TBH = 32'h8000_2004;

  rvfi_commit_monitor #(
    .NR_COMMIT_PORTS(2), .XLEN(64), .CNT_WIDTH(48), .TIMEOUT_CYCLES(100), .HANG_CYCLES(50)
  ) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_n), .clear_i(clear_a), .tohost_addr_i(tohost_a),
    .valid_i(valid_a), .trap_i(trap_a), .mem_addr_i(addr_a), .mem_wmask_i(wmask_a),
    .mem_wdata_i(wdata_a), .done_o(done_a), .end_reason_o(reason_a), .exit_code_o(exit_a),
    .cycles_o(cycles_a), .instret_o(instret_a), .trap_cnt_o(traps_a), .order_err_o(order_a)
  );

  rvfi_commit_monitor #(
    .NR_COMMIT_PORTS(2), .XLEN(32), .CNT_WIDTH(48), .TIMEOUT_CYCLES(0), .HANG_CYCLES(0)
  ) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_n), .clear_i(clear_b), .tohost_addr_i(tohost_b),
    .valid_i(valid_b), .trap_i(trap_b), .mem_addr_i(addr_b), .mem_wmask_i(wmask_b),
    .mem_wdata_i(wdata_b), .done_o(done_b), .end_reason_o(reason_b), .exit_code_o(exit_b),
    .cycles_o(cycles_b), .instret_o(instret_b), .trap_cnt_o(traps_b), .order_err_o(order_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [1:0] r,
                         input logic [63:0] x, input logic [47:0] c, input logic [47:0] ir,
                         input logic [47:0] tc, input logic oe);
    check({tag, " reason"}, 64'(r), 64'(e.reason));
    check({tag, " exit_code"}, x, e.exit_code);
    check({tag, " cycles"}, 64'(c), 64'(e.cycles));
    check({tag, " instret"}, 64'(ir), 64'(e.instret));
    check({tag, " trap_cnt"}, 64'(tc), 64'(e.traps));
    check({tag, " order_err"}, 64'(oe), 64'(e.order_err));
  endtask

  // Monitor: each rising done_o pops and checks one expected end-of-test record.
  always @(negedge clk_i) begin
    if (!rst_n) begin
      prev_a = 1'b0;
      prev_b = 1'b0;
    end else begin
      if (done_a && !prev_a) begin
        if (q_a.size() == 0) begin
          check("a unexpected done", 64'(done_a), 64'(0));
        end else begin
          e_a = q_a.pop_front();
          compare("a", e_a, reason_a, exit_a, cycles_a, instret_a, traps_a, order_a);
        end
      end
      if (done_b && !prev_b) begin
        if (q_b.size() == 0) begin
          check("b unexpected done", 64'(done_b), 64'(0));
        end else begin
          e_b = q_b.pop_front();
          compare("b", e_b, reason_b, exit_b, cycles_b, instret_b, traps_b, order_b);
        end
      end
      prev_a = done_a;
      prev_b = done_b;
    end
  end

  task automatic zero_inputs();
    clear_a = 1'b0; valid_a = '0; trap_a = '0; addr_a = '0; wmask_a = '0; wdata_a = '0;
    clear_b = 1'b0; valid_b = '0; trap_b = '0; addr_b = '0; wmask_b = '0; wdata_b = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk_i);
    zero_inputs();
  endtask

  task automatic put_a(input int p, input logic tr, input logic [63:0] ad,
                       input logic [7:0] m, input logic [63:0] d);
    valid_a[p] = 1'b1; trap_a[p] = tr;
    addr_a[p*64 +: 64] = ad; wmask_a[p*8 +: 8] = m; wdata_a[p*64 +: 64] = d;
  endtask

  task automatic put_b(input int p, input logic tr, input logic [31:0] ad,
                       input logic [3:0] m, input logic [31:0] d);
    valid_b[p] = 1'b1; trap_b[p] = tr;
    addr_b[p*32 +: 32] = ad; wmask_b[p*4 +: 4] = m; wdata_b[p*32 +: 32] = d;
  endtask

  task automatic push_a(input logic [1:0] r, input logic [63:0] x, input logic [47:0] c,
                        input logic [47:0] ir, input logic [47:0] tc, input logic oe);
    q_a.push_back('{reason: r, exit_code: x, cycles: c, instret: ir, traps: tc, order_err: oe});
  endtask

  task automatic push_b(input logic [1:0] r, input logic [63:0] x, input logic [47:0] c,
                        input logic [47:0] ir, input logic [47:0] tc, input logic oe);
    q_b.push_back('{reason: r, exit_code: x, cycles: c, instret: ir, traps: tc, order_err: oe});
  endtask

  // Pulse clear for one edge; returns at the negedge of cycle 0.
  task automatic start_a();
    next_cycle(); clear_a = 1'b1; next_cycle();
  endtask

  task automatic start_b();
    next_cycle(); clear_b = 1'b1; next_cycle();
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      next_cycle();
    end
    check("pending done events", 64'(q_a.size() + q_b.size()), 64'(0));
    q_a.delete();
    q_b.delete();
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, " a done"}, 64'(done_a), 64'(0));
    check({tag, " a reason"}, 64'(reason_a), 64'(0));
    check({tag, " a exit"}, exit_a, 64'(0));
    check({tag, " a cycles"}, 64'(cycles_a), 64'(0));
    check({tag, " a instret"}, 64'(instret_a), 64'(0));
    check({tag, " a traps"}, 64'(traps_a), 64'(0));
    check({tag, " a order"}, 64'(order_a), 64'(0));
  endtask

  task automatic check_zero_b(input string tag);
    check({tag, " b done"}, 64'(done_b), 64'(0));
    check({tag, " b reason"}, 64'(reason_b), 64'(0));
    check({tag, " b exit"}, exit_b, 64'(0));
    check({tag, " b cycles"}, 64'(cycles_b), 64'(0));
    check({tag, " b instret"}, 64'(instret_b), 64'(0));
    check({tag, " b traps"}, 64'(traps_b), 64'(0));
    check({tag, " b order"}, 64'(order_b), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    tohost_a = TA;
    tohost_b = TB;
    zero_inputs();
    repeat (3) @(negedge clk_i);
    check_zero_a("reset");
    check_zero_b("reset");
    rst_n = 1'b1;

    // 64-bit SD on port1 with port0 idle: ends test and flags the port gap
    start_a();
    push_a(2'b01, 64'h1, 48'd1, 48'd1, 48'd0, 1'b1);
    put_a(1, 1'b0, TA, 8'hFF, 64'h1);
    wait_drain(10);

    // Same-cycle conflict: lower port wins, both retire
    start_a();
    check_zero_a("clear");
    push_a(2'b01, 64'h5, 48'd1, 48'd2, 48'd0, 1'b0);
    put_a(0, 1'b0, TA, 8'hFF, 64'h5);
    put_a(1, 1'b0, TA, 8'hFF, 64'h7);
    wait_drain(10);

    // Traps, malformed tohost value blocking later ports, then a valid exit code
    start_a();
    push_a(2'b01, 64'h0000_FFFF_0000_0009, 48'd3, 48'd4, 48'd1, 1'b0);
    put_a(0, 1'b1, 64'h0, 8'h00, 64'h0);
    put_a(1, 1'b0, 64'h100, 8'h00, 64'h0);
    next_cycle();
    put_a(0, 1'b0, TA, 8'hFF, 64'h0001_0000_0000_0003);
    put_a(1, 1'b0, TA, 8'hFF, 64'h2);
    next_cycle();
    put_a(0, 1'b0, TA, 8'hFF, 64'h0000_FFFF_0000_0009);
    wait_drain(10);

    // Timeout at 100 cycles; periodic commits keep the hang watchdog quiet
    start_a();
    push_a(2'b10, 64'h0, 48'd100, 48'd10, 48'd0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (c > 0) next_cycle();
      if (c % 10 == 0) put_a(0, 1'b0, 64'h0, 8'h00, 64'h0);
    end
    wait_drain(20);

    // tohost in cycle 99 beats the timeout
    start_a();
    push_a(2'b01, 64'h1, 48'd100, 48'd11, 48'd0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (c > 0) next_cycle();
      if (c % 10 == 0) put_a(0, 1'b0, 64'h0, 8'h00, 64'h0);
      if (c == 99) put_a(0, 1'b0, TA, 8'hFF, 64'h1);
    end
    wait_drain(20);

    // Hang: last commit at cycle 10 -> ends at cycle 60
    start_a();
    push_a(2'b11, 64'h0, 48'd61, 48'd11, 48'd0, 1'b0);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next_cycle();
      put_a(0, 1'b0, 64'h0, 8'h00, 64'h0);
    end
    wait_drain(80);

    // Extra commit at cycle 40 moves the hang end to cycle 90
    start_a();
    push_a(2'b11, 64'h0, 48'd91, 48'd12, 48'd0, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) next_cycle();
      if (c <= 10 || c == 40) put_a(0, 1'b0, 64'h0, 8'h00, 64'h0);
    end
    wait_drain(80);
    repeat (5) next_cycle();
    check("a done sticky", 64'(done_a), 64'(1));
    check("a cycles frozen", 64'(cycles_a), 64'(91));
    check("a instret frozen", 64'(instret_a), 64'(12));

    // 32-bit SW pair, hi five cycles after lo
    start_b();
    push_b(2'b01, 64'h3, 48'd6, 48'd2, 48'd0, 1'b0);
    put_b(0, 1'b0, TB, 4'hF, 32'h3);
    repeat (5) next_cycle();
    put_b(0, 1'b0, TBH, 4'hF, 32'h0);
    wait_drain(10);

    // Bad hi returns to RUN; lone hi then ignored; same-cycle lo/hi pair completes
    start_b();
    push_b(2'b01, 64'h0000_0042_0000_0007, 48'd9, 48'd5, 48'd0, 1'b0);
    put_b(0, 1'b0, TB, 4'hF, 32'h3);
    repeat (2) next_cycle();
    put_b(0, 1'b0, TBH, 4'hF, 32'h0001_0000);
    repeat (2) next_cycle();
    put_b(0, 1'b0, TBH, 4'hF, 32'h0);
    repeat (3) next_cycle();
    check("b done after bad hi", 64'(done_b), 64'(0));
    next_cycle();
    put_b(0, 1'b0, TB, 4'hF, 32'h7);
    put_b(1, 1'b0, TBH, 4'hF, 32'h42);
    wait_drain(10);

    // Reset while in LO_SEEN discards the partial capture
    start_b();
    for (int c = 0; c <= 36; c++) begin
      if (c > 0) next_cycle();
      if (c < 36) put_b(0, 1'b0, 32'h0, 4'h0, 32'h0);
      else        put_b(0, 1'b0, TB, 4'hF, 32'h1);
    end
    next_cycle();
    check("b instret before reset", 64'(instret_b), 64'(37));
    check("b done before reset", 64'(done_b), 64'(0));
    rst_n = 1'b0;
    #1;
    check_zero_b("mid reset");
    next_cycle();
    rst_n = 1'b1;
    put_b(0, 1'b0, TBH, 4'hF, 32'h0);
    repeat (4) next_cycle();
    check("b done after lone hi", 64'(done_b), 64'(0));
    check("b exit after lone hi", exit_b, 64'(0));
    check("b reason after lone hi", 64'(reason_b), 64'(0));
    check("b instret after lone hi", 64'(instret_b), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
